imem_loader: RTL and testbench

//  Program loader: the write side of the 32x17 instruction memory that the fetch stage reads.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Packs every 3 bytes into one 17-bit instruction and drives the memory write port.
//  - Holds the core in reset (core_rstN low) until a complete program is loaded.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 178 +++++++++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Desc     : Byte-stream handshake and instruction-memory write port of the loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int AW = 5,
  parameter int IW = 17
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;

  // master is the loader itself; slave is the byte source / memory side
  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Desc     : Packs a 3-byte-per-word stream into the 32x17 instruction memory and
//            holds the core in reset until the program is complete.
//            Optional trailing XOR checksum byte: define IMEM_LOADER_CKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int AW = 5,
  parameter int IW = 17
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          start,
  input  logic [AW:0]   len,
  imem_loader_if.master bus,
  output logic          core_rstN,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
`ifdef IMEM_LOADER_CKSUM_EN
    ,S_CK  = 3'd6
`endif
  } state_t;

  localparam logic [AW:0] c_depth = (AW+1)'(1) << AW;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam state_t c_last = S_CK;
`else
  localparam state_t c_last = S_DONE;
`endif

  state_t        r_state;
  logic [AW:0]   r_len;
  logic [AW:0]   r_wptr;
  logic [8:0]    r_hi;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_core_rstN;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [IW-1:0] r_mem_wdata;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]    r_cksum;
`endif

  logic        w_take;
  logic [AW:0] w_wptr_nxt;

  assign w_take     = bus.in_valid & r_in_ready;
  assign w_wptr_nxt = r_wptr + 1'b1;

  // status outputs are registered together with the state they describe
  function automatic logic [4:0] f_flags(input state_t s);
    logic act;
    act = (s == S_B0) || (s == S_B1) || (s == S_B2)
`ifdef IMEM_LOADER_CKSUM_EN
          || (s == S_CK)
`endif
          ;
    return {act, act, s == S_DONE, s == S_ERR, s == S_DONE};
  endfunction

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_wptr      <= '0;
      r_hi        <= '0;
      {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      r_cksum     <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      if (w_take && r_state != S_CK) r_cksum <= r_cksum ^ bus.in_data;
`endif
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_len  <= len;
            r_wptr <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            r_cksum <= '0;
`endif
            if (len == '0 || len > c_depth) begin
              r_state <= S_ERR;
              {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_ERR);
            end else begin
              r_state <= S_B0;
              {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_B0);
            end
          end
        end
        S_B0: begin
          if (w_take) begin
            r_hi[8] <= bus.in_data[0];
            if (|bus.in_data[7:1]) begin
              r_state <= S_ERR;
              {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_ERR);
            end else begin
              r_state <= S_B1;
              {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_B1);
            end
          end
        end
        S_B1: begin
          if (w_take) begin
            r_hi[7:0] <= bus.in_data;
            r_state   <= S_B2;
            {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_B2);
          end
        end
        S_B2: begin
          if (w_take) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wptr[AW-1:0];
            r_mem_wdata <= {r_hi, bus.in_data};
            r_wptr      <= w_wptr_nxt;
            if (w_wptr_nxt == r_len) begin
              r_state <= c_last;
              {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(c_last);
            end else begin
              r_state <= S_B0;
              {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_B0);
            end
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        S_CK: begin
          if (w_take) begin
            if (bus.in_data == r_cksum) begin
              r_state <= S_DONE;
              {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_DONE);
            end else begin
              r_state <= S_ERR;
              {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_ERR);
            end
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          {r_in_ready, r_busy, r_done, r_err, r_core_rstN} <= f_flags(S_IDLE);
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign core_rstN     = r_core_rstN;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Desc     : Scoreboard bench for imem_loader; expected writes are queued by the
//            stimulus and popped by a write monitor. IMEM_LOADER_CKSUM_EN aware.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
  localparam int AW = 5;
  localparam int IW = 17;

  logic          clk;
  logic          rstN;
  logic          start;
  logic [AW:0]   len;
  logic          core_rstN;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader_if #(.AW(AW), .IW(IW)) bus ();

  imem_loader #(.AW(AW), .IW(IW)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .len       (len),
    .bus       (bus),
    .core_rstN (core_rstN),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [AW+IW-1:0] exp_q[$];
  logic [7:0] tb_x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // write monitor: every mem_we must match the oldest expected write
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.mem_addr, bus.mem_wdata}, '0);
      end else begin
        logic [AW+IW-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e[AW+IW-1:IW]));
        check("wr_data", 32'(bus.mem_wdata), 32'(e[IW-1:0]));
      end
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic [IW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic start_load(input logic [AW:0] l);
    start = 1'b1;
    len   = l;
    tb_x  = 8'h00;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tb_x = tb_x ^ b;
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int gap);
    send_byte(b0, gap);
    send_byte(b1, gap);
    send_byte(b2, gap);
    check("we_latency", 32'(bus.mem_we), 32'd1);
  endtask

  task automatic end_load();
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(tb_x, 0);
`endif
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; len = '0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_flags", {28'd0, bus.in_ready, busy, done, err}, 32'd0);
    check("rst_core_rstN", 32'(core_rstN), 32'd0);
    check("rst_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    // normal load
    push_exp(5'd0, 17'h12345);
    push_exp(5'd1, 17'h0FF00);
    start_load(6'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_core_rst_held", 32'(core_rstN), 32'd0);
    send_word(8'h01, 8'h23, 8'h45, 0);
    send_word(8'h00, 8'hFF, 8'h00, 0);
    end_load();
    check("t1_done", {29'd0, done, core_rstN, busy}, 32'b110);

    // backpressure gaps between bytes
    push_exp(5'd0, 17'h12345);
    push_exp(5'd1, 17'h0FF00);
    start_load(6'd2);
    send_word(8'h01, 8'h23, 8'h45, 3);
    send_word(8'h00, 8'hFF, 8'h00, 3);
    end_load();
    check("t2_done", {29'd0, done, core_rstN, busy}, 32'b110);

    // reserved bit error, then recovery
    start_load(6'd2);
    send_byte(8'h02, 0);
    check("t3_err", {28'd0, err, core_rstN, bus.in_ready, done}, 32'b1000);
    push_exp(5'd0, 17'h12345);
    start_load(6'd1);
    send_word(8'h01, 8'h23, 8'h45, 0);
    end_load();
    check("t3_recover", {29'd0, done, core_rstN, err}, 32'b110);

    // illegal lengths; start while busy is ignored
    start_load(6'd0);
    check("t4_len0_err", {30'd0, err, busy}, 32'b10);
    start_load(6'd1);
    check("t4_restart", {30'd0, err, busy}, 32'b01);
    start_load(6'd33);
    check("t4_start_while_busy", {30'd0, err, busy}, 32'b01);
    push_exp(5'd0, 17'h1A5C3);
    send_word(8'h01, 8'hA5, 8'hC3, 0);
    end_load();
    check("t4_done", 32'(done), 32'd1);
    start_load(6'd33);
    check("t4_len33_err", {29'd0, err, busy, core_rstN}, 32'b100);

    // full depth, no wrap
    start_load(6'd32);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] bi;
      bi = 8'(i);
      push_exp(5'(i), {bi[0], bi, ~bi});
      send_word({7'd0, bi[0]}, bi, ~bi, 0);
    end
    end_load();
    check("t5_done", {30'd0, done, core_rstN}, 32'b11);
    bus.in_valid = 1'b1; bus.in_data = 8'h00;
    check("t5_no_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("t5_still_done", 32'(done), 32'd1);

    // reset mid-load after 4 bytes
    push_exp(5'd0, 17'h12345);
    start_load(6'd4);
    send_word(8'h01, 8'h23, 8'h45, 0);
    send_byte(8'h01, 0);
    rstN = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    @(negedge clk);
    check("t6_rst_flags", {27'd0, busy, bus.in_ready, done, err, core_rstN}, 32'd0);
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check("t6_idle", 32'(bus.in_ready), 32'd0);
    push_exp(5'd0, 17'h00001);
    start_load(6'd1);
    send_word(8'h00, 8'h00, 8'h01, 0);
    end_load();
    check("t6_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CKSUM_EN
    push_exp(5'd0, 17'h12345);
    start_load(6'd1);
    send_word(8'h01, 8'h23, 8'h45, 0);
    check("ck_wait", {30'd0, busy, done}, 32'b10);
    send_byte(8'h67, 0);
    check("ck_good", {30'd0, done, err}, 32'b10);
    push_exp(5'd0, 17'h12345);
    start_load(6'd1);
    send_word(8'h01, 8'h23, 8'h45, 0);
    send_byte(8'h66, 0);
    check("ck_bad", {29'd0, done, err, core_rstN}, 32'b010);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
